// File: rtl/io_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : io_uart_tx_pkg
// Brief   : Shared FSM encoding, defaults and bit-period clamp for io_uart_tx.
// Revision: 1.0
// ============================================================================
package io_uart_tx_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int ADR_W_DEF = 4;
    localparam int TERM_MIN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [15:0] clamp_term(input logic [15:0] term);
        return (term < 16'(TERM_MIN)) ? 16'(TERM_MIN) : term;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Flop-based synchronous FIFO; head entry is read straight from storage.
// Revision: 1.0
// ============================================================================
module uart_tx_fifo
    import io_uart_tx_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADR_W = ADR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [7:0]       din_i,
    output logic [7:0]       dout_o,
    output logic [ADR_W:0]   count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam logic [ADR_W:0] C_DEPTH = (ADR_W+1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [ADR_W-1:0] wr_ptr_q;
    logic [ADR_W-1:0] rd_ptr_q;
    logic [ADR_W:0]   count_q;
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    assign w_push  = push_i & (~full_o | pop_i);
    assign w_pop   = pop_i & ~empty_o;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == C_DEPTH);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : io_uart_tx
// Brief   : Buffered 8N1 UART transmitter with CPU/echo arbitration.
// Revision: 1.0
// ============================================================================
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADR_W = ADR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_io_char,
    input  logic        uart_io_we,
    input  logic [7:0]  echo_char,
    input  logic        echo_we,
    input  logic [15:0] uart_term,
    output logic        uart_io_full,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        tx_overflow
);

    localparam logic [ADR_W:0] C_ALMOST = (ADR_W+1)'(DEPTH - 1);

    tx_state_e      state_q;
    logic [7:0]     shift_q;
    logic [15:0]    term_q;
    logic [15:0]    baud_q;
    logic [2:0]     bit_cnt_q;
    logic           tx_q;
    logic           overflow_q;

    logic [7:0]     w_head;
    logic [ADR_W:0] w_count;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic [7:0]     w_din;
    logic           w_baud_done;
    logic [15:0]    w_term_new;

    assign w_baud_done = (baud_q == 16'd0);
    assign w_term_new  = clamp_term(uart_term);
    assign w_pop       = ~w_empty & ((state_q == ST_IDLE) |
                                     ((state_q == ST_STOP) & w_baud_done));
    // CPU writes win; a colliding echo character is silently lost.
    assign w_push      = uart_io_we | echo_we;
    assign w_din       = uart_io_we ? uart_io_char : echo_char;

    assign uart_io_full = (w_count >= C_ALMOST);
    assign uart_tx      = tx_q;
    assign tx_busy      = (state_q != ST_IDLE) | ~w_empty;
    assign tx_overflow  = overflow_q;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .ADR_W (ADR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_din),
        .dout_o  (w_head),
        .count_o (w_count),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (uart_io_we & w_full & ~w_pop) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            term_q    <= '0;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        shift_q <= w_head;
                        term_q  <= w_term_new;
                        baud_q  <= w_term_new - 16'd1;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        baud_q    <= term_q - 16'd1;
                        bit_cnt_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        baud_q <= term_q - 16'd1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (w_pop) begin
                            shift_q <= w_head;
                            term_q  <= w_term_new;
                            baud_q  <= w_term_new - 16'd1;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_io_uart_tx
// Brief   : Self-checking bench; expected line waveforms are built from 8N1 frame rules.
// Revision: 1.0
// ============================================================================
module tb_io_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  uart_io_char = '0;
    logic        uart_io_we = 1'b0;
    logic [7:0]  echo_char = '0;
    logic        echo_we = 1'b0;
    logic [15:0] uart_term = 16'd4;
    logic        uart_io_full;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_overflow;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic v;
        int   len;
    } seg_t;

    seg_t exp_q[$];
    logic rec_en = 1'b0;
    logic rec_tx[$];
    logic rec_busy[$];
    logic rec_full[$];
    logic rec_ovf[$];

    io_uart_tx dut (
        .clk          (clk),
        .rst          (rst),
        .uart_io_char (uart_io_char),
        .uart_io_we   (uart_io_we),
        .echo_char    (echo_char),
        .echo_we      (echo_we),
        .uart_term    (uart_term),
        .uart_io_full (uart_io_full),
        .uart_tx      (uart_tx),
        .tx_busy      (tx_busy),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec_en) begin
            rec_tx.push_back(uart_tx);
            rec_busy.push_back(tx_busy);
            rec_full.push_back(uart_io_full);
            rec_ovf.push_back(tx_overflow);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        uart_io_we = 1'b0;
        echo_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic start_rec();
        rec_tx.delete();
        rec_busy.delete();
        rec_full.delete();
        rec_ovf.delete();
        exp_q.delete();
        rec_en = 1'b1;
    endtask

    function automatic void add_idle(int n);
        exp_q.push_back('{1'b1, n});
    endfunction

    // Reference frame: start bit, eight data bits LSB first, stop bit, each one bit period.
    function automatic int add_frame(logic [7:0] b, int term);
        int t;
        t = (term < 2) ? 2 : term;
        exp_q.push_back('{1'b0, t});
        for (int i = 0; i < 8; i++) exp_q.push_back('{b[i], t});
        exp_q.push_back('{1'b1, t});
        return 10 * t;
    endfunction

    task automatic clear_inputs();
        uart_io_we = 1'b0;
        echo_we = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        vectors++;
        if (uart_io_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", uart_io_full); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        vectors++;
        if (tx_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", tx_overflow); end

        uart_term = 16'd4;
        uart_io_char = 8'h55;
        uart_io_we = 1'b1;
        tick();
        clear_inputs();
        repeat (12) tick();
        // Cycle N+13: data bit 1 of 0x55 is on the line.
        vectors++;
        if (uart_tx !== 1'b0) begin miscompares++; $display("FAIL middata_tx: got %b want 0", uart_tx); end
        vectors++;
        if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL middata_busy: got %b want 1", tx_busy); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: got %b want 1", uart_tx); end
        vectors++;
        if (uart_io_full !== 1'b0) begin miscompares++; $display("FAIL rstmid_full: got %b want 0", uart_io_full); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
        #3 rst = 1'b0;
        repeat (20) tick();
        vectors++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_rst_idle: tx=%b busy=%b want tx=1 busy=0", uart_tx, tx_busy);
        end
    endtask

    task automatic test_single();
        int total, pos, bad;
        logic first_bad;
        apply_reset();
        uart_term = 16'd4;
        start_rec();
        add_idle(2);
        total = 2 + add_frame(8'h55, 4) + 3;
        add_idle(3);
        for (int c = 0; c < total; c++) begin
            clear_inputs();
            if (c == 0) begin uart_io_char = 8'h55; uart_io_we = 1'b1; end
            tick();
        end
        clear_inputs();
        rec_en = 1'b0;
        pos = 0;
        foreach (exp_q[k]) begin
            bad = 0; first_bad = 1'bx;
            for (int j = 0; j < exp_q[k].len; j++)
                if (pos + j >= rec_tx.size() || rec_tx[pos + j] !== exp_q[k].v) begin
                    if (bad == 0 && pos + j < rec_tx.size()) first_bad = rec_tx[pos + j];
                    bad++;
                end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL single_wave seg %0d @%0d: got %b in %0d/%0d samples, want %b", k, pos, first_bad, bad, exp_q[k].len, exp_q[k].v);
            end
            pos += exp_q[k].len;
        end
        vectors++;
        if (rec_busy[0] !== 1'b0 || rec_busy[1] !== 1'b1 || rec_busy[41] !== 1'b1 || rec_busy[42] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy: got %b%b%b%b want 0110", rec_busy[0], rec_busy[1], rec_busy[41], rec_busy[42]);
        end
    endtask

    task automatic test_random();
        int total, pos, bad, t;
        logic first_bad;
        logic [7:0] b;
        for (int it = 0; it < 5; it++) begin
            apply_reset();
            t = int'($urandom_range(0, 6));
            b = 8'($urandom);
            uart_term = 16'(t);
            start_rec();
            add_idle(2);
            total = 2 + add_frame(b, t) + 4;
            add_idle(4);
            for (int c = 0; c < total; c++) begin
                clear_inputs();
                if (c == 0) begin uart_io_char = b; uart_io_we = 1'b1; end
                tick();
            end
            clear_inputs();
            rec_en = 1'b0;
            pos = 0;
            foreach (exp_q[k]) begin
                bad = 0; first_bad = 1'bx;
                for (int j = 0; j < exp_q[k].len; j++)
                    if (pos + j >= rec_tx.size() || rec_tx[pos + j] !== exp_q[k].v) begin
                        if (bad == 0 && pos + j < rec_tx.size()) first_bad = rec_tx[pos + j];
                        bad++;
                    end
                vectors++;
                if (bad != 0) begin
                    miscompares++;
                    $display("FAIL random_wave byte %h term %0d seg %0d: got %b in %0d samples, want %b", b, t, k, first_bad, bad, exp_q[k].v);
                end
                pos += exp_q[k].len;
            end
        end
    endtask

    task automatic test_back_to_back();
        int total, pos, bad;
        logic first_bad;
        logic [7:0] bytes [16];
        apply_reset();
        uart_term = 16'd8;
        start_rec();
        add_idle(2);
        total = 2;
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'($urandom);
            total += add_frame(bytes[i], 8);
        end
        add_idle(3);
        total += 3;
        for (int c = 0; c < total; c++) begin
            clear_inputs();
            if (c < 16) begin uart_io_char = bytes[c]; uart_io_we = 1'b1; end
            tick();
        end
        clear_inputs();
        rec_en = 1'b0;
        pos = 0;
        foreach (exp_q[k]) begin
            bad = 0; first_bad = 1'bx;
            for (int j = 0; j < exp_q[k].len; j++)
                if (pos + j >= rec_tx.size() || rec_tx[pos + j] !== exp_q[k].v) begin
                    if (bad == 0 && pos + j < rec_tx.size()) first_bad = rec_tx[pos + j];
                    bad++;
                end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL b2b_wave seg %0d @%0d: got %b in %0d samples, want %b", k, pos, first_bad, bad, exp_q[k].v);
            end
            pos += exp_q[k].len;
        end
        // One byte leaves at once, so occupancy is 14 during cycle 15 and 15 during cycle 16.
        vectors++;
        if (rec_full[15] !== 1'b0) begin miscompares++; $display("FAIL b2b_full_at14: got %b want 0", rec_full[15]); end
        vectors++;
        if (rec_full[16] !== 1'b1) begin miscompares++; $display("FAIL b2b_full_at15: got %b want 1", rec_full[16]); end
    endtask

    task automatic test_overflow();
        int total, pos, bad;
        logic first_bad;
        logic [7:0] bytes [18];
        apply_reset();
        uart_term = 16'd4;
        start_rec();
        add_idle(2);
        total = 2;
        for (int i = 0; i < 18; i++) bytes[i] = 8'($urandom);
        // Seventeen bytes fit (one popped immediately plus sixteen stored); the eighteenth is lost.
        for (int i = 0; i < 17; i++) total += add_frame(bytes[i], 4);
        add_idle(3);
        total += 3;
        for (int c = 0; c < total; c++) begin
            clear_inputs();
            if (c < 18) begin uart_io_char = bytes[c]; uart_io_we = 1'b1; end
            if (c == 18) begin echo_char = ~bytes[0]; echo_we = 1'b1; end
            tick();
        end
        clear_inputs();
        rec_en = 1'b0;
        pos = 0;
        foreach (exp_q[k]) begin
            bad = 0; first_bad = 1'bx;
            for (int j = 0; j < exp_q[k].len; j++)
                if (pos + j >= rec_tx.size() || rec_tx[pos + j] !== exp_q[k].v) begin
                    if (bad == 0 && pos + j < rec_tx.size()) first_bad = rec_tx[pos + j];
                    bad++;
                end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL ovf_wave seg %0d @%0d: got %b in %0d samples, want %b", k, pos, first_bad, bad, exp_q[k].v);
            end
            pos += exp_q[k].len;
        end
        vectors++;
        if (rec_ovf[17] !== 1'b0) begin miscompares++; $display("FAIL ovf_before_drop: got %b want 0", rec_ovf[17]); end
        vectors++;
        if (rec_ovf[18] !== 1'b1) begin miscompares++; $display("FAIL ovf_after_drop: got %b want 1", rec_ovf[18]); end
        vectors++;
        if (rec_full[18] !== 1'b1 || rec_ovf[19] !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_echo_full: full=%b ovf=%b want 1 1", rec_full[18], rec_ovf[19]);
        end
        vectors++;
        if (tx_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", tx_overflow); end
    endtask

    task automatic test_collision();
        int total, pos, bad;
        logic first_bad;
        logic [7:0] e;
        apply_reset();
        uart_term = 16'd4;
        e = 8'($urandom);
        start_rec();
        add_idle(2);
        total = 2 + add_frame(8'h41, 4);
        add_idle(20);
        total += 20 + add_frame(e, 4) + 3;
        add_idle(3);
        for (int c = 0; c < total; c++) begin
            clear_inputs();
            if (c == 0) begin
                uart_io_char = 8'h41; uart_io_we = 1'b1;
                echo_char = 8'h42; echo_we = 1'b1;
            end
            if (c == 60) begin echo_char = e; echo_we = 1'b1; end
            tick();
        end
        clear_inputs();
        rec_en = 1'b0;
        pos = 0;
        foreach (exp_q[k]) begin
            bad = 0; first_bad = 1'bx;
            for (int j = 0; j < exp_q[k].len; j++)
                if (pos + j >= rec_tx.size() || rec_tx[pos + j] !== exp_q[k].v) begin
                    if (bad == 0 && pos + j < rec_tx.size()) first_bad = rec_tx[pos + j];
                    bad++;
                end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL collision_wave seg %0d @%0d: got %b in %0d samples, want %b", k, pos, first_bad, bad, exp_q[k].v);
            end
            pos += exp_q[k].len;
        end
        vectors++;
        if (tx_overflow !== 1'b0) begin miscompares++; $display("FAIL collision_ovf: got %b want 0", tx_overflow); end
    endtask

    task automatic test_term_change();
        int total, pos, bad;
        logic first_bad;
        logic [7:0] b2, b3;
        apply_reset();
        uart_term = 16'd4;
        b2 = 8'($urandom);
        b3 = 8'($urandom);
        start_rec();
        add_idle(2);
        total = 2 + add_frame(8'hA5, 4) + add_frame(b2, 6);
        add_idle(10);
        total += 10 + add_frame(b3, 0) + 3;
        add_idle(3);
        for (int c = 0; c < total; c++) begin
            clear_inputs();
            if (c == 0)   begin uart_io_char = 8'hA5; uart_io_we = 1'b1; end
            if (c == 1)   begin uart_io_char = b2; uart_io_we = 1'b1; end
            if (c == 10)  uart_term = 16'd6;
            if (c == 105) uart_term = 16'd0;
            if (c == 110) begin uart_io_char = b3; uart_io_we = 1'b1; end
            tick();
        end
        clear_inputs();
        rec_en = 1'b0;
        pos = 0;
        foreach (exp_q[k]) begin
            bad = 0; first_bad = 1'bx;
            for (int j = 0; j < exp_q[k].len; j++)
                if (pos + j >= rec_tx.size() || rec_tx[pos + j] !== exp_q[k].v) begin
                    if (bad == 0 && pos + j < rec_tx.size()) first_bad = rec_tx[pos + j];
                    bad++;
                end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL term_wave seg %0d @%0d: got %b in %0d samples, want %b", k, pos, first_bad, bad, exp_q[k].v);
            end
            pos += exp_q[k].len;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_overflow();
        test_collision();
        test_term_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
